// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation, E-stage forwarding
// selects, mul/div occupancy tracking and saturating event counters.
module hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteE,
    input  logic             PCSrcE,
    input  logic             MulDivE,
    input  logic             RegWriteM,
    input  logic [REG_W-1:0] RdM,
    input  logic             DMemReqM,
    input  logic             DMemReadyM,
    input  logic             RegWriteW,
    input  logic [REG_W-1:0] RdW,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] RedirectCount
);

    localparam int CW = $clog2(DIV_LAT + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic mem_stall;
    logic div_stall;
    logic stall_e;
    logic lw_stall;
    logic rd_hit;

    assign mem_stall = DMemReqM & ~DMemReadyM;

    always_comb begin
        div_stall = 1'b0;
        unique case (state)
            IDLE: div_stall = MulDivE & ~mem_stall;
            BUSY: div_stall = (cnt != '0);
            default: div_stall = 1'b0;
        endcase
    end

    // cnt freezes while memory holds the pipe; a dropped MulDivE means
    // the op was flushed out of E, so abandon it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (MulDivE && !mem_stall) begin
                        state <= BUSY;
                        cnt   <= CW'(DIV_LAT - 1);
                    end
                end
                BUSY: begin
                    if (!MulDivE) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!mem_stall) begin
                        if (cnt == '0) state <= IDLE;
                        else           cnt   <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign stall_e  = mem_stall | div_stall;
    assign rd_hit   = (Rs1D == RdE) | (Rs2D == RdE);
    assign lw_stall = ResultSrcE[0] & RegWriteE & (RdE != '0) & rd_hit & ~stall_e;

    assign StallF = mem_stall | div_stall | lw_stall;
    assign StallD = StallF;
    assign StallE = stall_e;
    assign StallM = mem_stall;

    assign FlushW = mem_stall;
    assign FlushM = div_stall & ~mem_stall;
    assign FlushE = (lw_stall | PCSrcE) & ~stall_e;
    assign FlushD = PCSrcE & ~stall_e;

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && RdM == Rs1E && Rs1E != '0)      ForwardAE = 2'b10;
        else if (RegWriteW && RdW == Rs1E && Rs1E != '0) ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && RdM == Rs2E && Rs2E != '0)      ForwardBE = 2'b10;
        else if (RegWriteW && RdW == Rs2E && Rs2E != '0) ForwardBE = 2'b01;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            StallCycles   <= '0;
            RedirectCount <= '0;
        end else begin
            if (StallF && StallCycles != '1)
                StallCycles <= StallCycles + CNT_W'(1);
            if (FlushD && RedirectCount != '1)
                RedirectCount <= RedirectCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector scoreboard bench for hazard_ctrl (DIV_LAT=4, CNT_W=3).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteE, PCSrcE, MulDivE, RegWriteM;
    logic       DMemReqM, DMemReadyM, RegWriteW;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushM, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic [2:0] StallCycles, RedirectCount;

    hazard_ctrl #(.REG_W(5), .DIV_LAT(4), .CNT_W(3)) dut (
        .clk(clk), .resetn(resetn),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .PCSrcE(PCSrcE),
        .MulDivE(MulDivE), .RegWriteM(RegWriteM), .RdM(RdM),
        .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
        .RegWriteW(RegWriteW), .RdW(RdW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCycles(StallCycles), .RedirectCount(RedirectCount)
    );

    always #5 clk = ~clk;

    // flag order: {SF,SD,SE,SM,FD,FE,FM,FW}
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] LW   = 8'b1100_0100;
    localparam logic [7:0] DIV  = 8'b1110_0010;
    localparam logic [7:0] MEM  = 8'b1111_0001;
    localparam logic [7:0] BR   = 8'b0000_1100;
    localparam logic [7:0] LWBR = 8'b1100_1100;

    typedef struct packed {
        logic [7:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [2:0] sc;
        logic [2:0] rc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; RegWriteE = 0; PCSrcE = 0; MulDivE = 0;
        RegWriteM = 0; DMemReqM = 0; DMemReadyM = 0; RegWriteW = 0;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        ResultSrcE = 2'b01; RegWriteE = 1; RdE = rd; Rs1D = r1; Rs2D = r2;
    endtask

    task automatic cyc(input logic [7:0] fl, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [2:0] sc, input logic [2:0] rc);
        exp_t e;
        e = '{fl: fl, fa: fa, fb: fb, sc: sc, rc: rc};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = q.pop_front();
            a.fl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};
            a.fa = ForwardAE;
            a.fb = ForwardBE;
            a.sc = StallCycles;
            a.rc = RedirectCount;
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL vec%0d: got fl=%b fa=%0d fb=%0d sc=%0d rc=%0d want fl=%b fa=%0d fb=%0d sc=%0d rc=%0d",
                         n_vec, a.fl, a.fa, a.fb, a.sc, a.rc, e.fl, e.fa, e.fb, e.sc, e.rc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d vectors pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        resetn = 1;
        #2 resetn = 0;
        @(posedge clk);
        #1;
        cyc(NONE, 0, 0, 0, 0);
        resetn = 1;

        // load-use
        ld(5, 5, 0); cyc(LW, 0, 0, 0, 0);
        ld(0, 5, 0); cyc(NONE, 0, 0, 1, 0);
        ld(5, 0, 5); cyc(LW, 0, 0, 1, 0);
        clr();       cyc(NONE, 0, 0, 2, 0);
        resetn = 0;  cyc(NONE, 0, 0, 0, 0);
        resetn = 1;

        // plain mul/div: 4 stall cycles then release
        MulDivE = 1;
        cyc(DIV, 0, 0, 0, 0);
        cyc(DIV, 0, 0, 1, 0);
        cyc(DIV, 0, 0, 2, 0);
        cyc(DIV, 0, 0, 3, 0);
        cyc(NONE, 0, 0, 4, 0);
        clr(); cyc(NONE, 0, 0, 4, 0);

        // mul/div frozen by memory wait, counter saturates, branch held off
        MulDivE = 1;   cyc(DIV, 0, 0, 4, 0);
        DMemReqM = 1;  cyc(MEM, 0, 0, 5, 0);
        cyc(MEM, 0, 0, 6, 0);
        cyc(MEM, 0, 0, 7, 0);
        DMemReqM = 0;  cyc(DIV, 0, 0, 7, 0);
        PCSrcE = 1;    cyc(DIV, 0, 0, 7, 0);
        cyc(DIV, 0, 0, 7, 0);
        cyc(BR, 0, 0, 7, 0);
        clr();         cyc(NONE, 0, 0, 7, 1);

        // memStall blocks start; external flush aborts BUSY
        MulDivE = 1; DMemReqM = 1; cyc(MEM, 0, 0, 7, 1);
        DMemReqM = 0; cyc(DIV, 0, 0, 7, 1);
        MulDivE = 0;  cyc(DIV, 0, 0, 7, 1);
        cyc(NONE, 0, 0, 7, 1);

        // load-use with branch; load-use masked by memStall
        ld(5, 5, 0); PCSrcE = 1; cyc(LWBR, 0, 0, 7, 1);
        PCSrcE = 0; DMemReqM = 1; cyc(MEM, 0, 0, 7, 2);
        clr(); cyc(NONE, 0, 0, 7, 2);

        // forwarding
        RegWriteM = 1; RegWriteW = 1; RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 7;
        cyc(NONE, 2, 2, 7, 2);
        RegWriteM = 0; cyc(NONE, 1, 1, 7, 2);
        Rs1E = 0; Rs2E = 0; cyc(NONE, 0, 0, 7, 2);
        RegWriteM = 1; Rs1E = 7; Rs2E = 3; RdW = 3; cyc(NONE, 2, 1, 7, 2);

        // reset mid-BUSY
        clr(); MulDivE = 1; cyc(DIV, 0, 0, 7, 2);
        clr(); resetn = 0;  cyc(NONE, 0, 0, 0, 0);
        resetn = 1;         cyc(NONE, 0, 0, 0, 0);
        MulDivE = 1;
        cyc(DIV, 0, 0, 0, 0);
        cyc(DIV, 0, 0, 1, 0);
        cyc(DIV, 0, 0, 2, 0);
        cyc(DIV, 0, 0, 3, 0);
        cyc(NONE, 0, 0, 4, 0);
        clr(); cyc(NONE, 0, 0, 4, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the five-stage RISC-V pipeline. It resolves load-use, branch, multi-cycle multiply/divide and data-memory wait hazards, and drives per-stage stall and flush signals plus the E-stage forwarding selects. It also keeps saturating stall and redirect event counters for performance analysis. It sits beside the pipeline registers and is the single source of every stall and flush in the core.

## Interface
Parameters:
- REG_W, 5, register-address width
- DIV_LAT, 32, E-stage occupancy of a mul/div op minus one; legal range ≥1
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  REG_W  source registers in D
- Rs1E, Rs2E, RdE  in  REG_W  source and destination registers in E
- ResultSrcE  in  2  bit0=1 means the E instruction is a load
- RegWriteE  in  1  E instruction writes rd
- PCSrcE  in  1  branch/jump taken in E
- MulDivE  in  1  E instruction is a multi-cycle mul/div
- RegWriteM, RdM  in  1, REG_W  M-stage writeback info
- DMemReqM, DMemReadyM  in  1, 1  data-memory request and ready in M
- RegWriteW, RdW  in  1, REG_W  W-stage writeback info
- StallF, StallD, StallE, StallM  out  1  hold the respective pipeline register
- FlushD, FlushE, FlushM, FlushW  out  1  load a bubble into the respective register
- ForwardAE, ForwardBE  out  2  00=RF, 01=W result, 10=M ALU result
- StallCycles, RedirectCount  out  CNT_W  saturating event counters

## Operation
- memStall = DMemReqM & ~DMemReadyM. It has the highest priority.
- Mul/div FSM:
  - State IDLE: if MulDivE & ~memStall, load cnt = DIV_LAT-1, go to BUSY, and assert divStall this cycle.
  - State BUSY: divStall = (cnt≠0). cnt decrements each cycle unless memStall.
  - In BUSY with cnt==0 and ~memStall: go to IDLE with divStall low, so the op leaves E.
  - Total divStall cycles = DIV_LAT. E occupancy = DIV_LAT+1 cycles.
- stallE = memStall | divStall.
- lwStall = ResultSrcE[0] & RegWriteE & (RdE≠0) & ((Rs1D==RdE)|(Rs2D==RdE)) & ~stallE.
- StallF = StallD = memStall | divStall | lwStall. StallE = stallE. StallM = memStall.
- Flushes:
  - FlushW = memStall.
  - FlushM = divStall & ~memStall.
  - FlushE = (lwStall | PCSrcE) & ~stallE.
  - FlushD = PCSrcE & ~stallE.
- A branch resolving in a stalled E is acted on only in its first unstalled cycle.
- Forwarding (A shown; B is identical with Rs2E):
  - 10 if RegWriteM & RdM==Rs1E & Rs1E≠0;
  - else 01 if RegWriteW & RdW==Rs1E & Rs1E≠0;
  - else 00.
  - M has priority over W.
- Counters:
  - StallCycles increments on every cycle with StallF=1.
  - RedirectCount increments on every cycle with FlushD=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.

## Timing
- Stall, flush and forward outputs are combinational from inputs and FSM state, with zero latency. Counters update on the clock edge.
- Reset (async assert, sync release) forces state IDLE, cnt=0 and both counters 0. With inputs at 0, all outputs read 0.
- Reset asserted mid mul/div aborts the op. The FSM restarts in IDLE.
- MulDivE must stay asserted while the op is held in E. If MulDivE deasserts in BUSY (E flushed externally), the FSM returns to IDLE next cycle.
- Simultaneous memStall and MulDivE in IDLE: the FSM does not start until memStall clears.
- lwStall and PCSrcE in the same cycle: FlushE=1, FlushD=1 and StallF/StallD=1. The redirect PC load wins at the PC mux.

## Test plan
- Load x5 in E (ResultSrcE=01, RegWriteE=1, RdE=5) with Rs1D=5 → StallF=StallD=FlushE=1 for 1 cycle. Repeat with RdE=0 → no stall.
- DIV_LAT=4, MulDivE held → StallF/D/E=1 for exactly 4 cycles, FlushM=1 those cycles, release on cycle 5. StallCycles=4.
- DMemReqM=1, DMemReadyM=0 for 3 cycles during a BUSY mul/div → cnt frozen, StallM=FlushW=1 for 3 cycles, divStall total still 4 unstalled cycles.
- PCSrcE=1 while divStall=1 → FlushD=FlushE=0. After release, PCSrcE=1 → FlushD=FlushE=1 and RedirectCount+1.
- Rs1E=Rs2E=7, RdM=RdW=7, both RegWrite=1 → ForwardAE=ForwardBE=10. Clear RegWriteM → 01. Rs=0 → 00.
- CNT_W=3, hold a stall for 10 cycles → StallCycles saturates at 7. Pulse resetn low mid-BUSY → all counters 0 and FSM IDLE.
